// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Arbitrates two register-file write requesters (A and B) with round-robin
//   fairness, and runs a clear sweep that zeroes every register one per cycle.
//   The register-file write port (rf_write / rf_inaddress / rf_in) is
//   registered, so an accepted write appears one cycle after its transfer.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   a_valid/a_addr/a_data : requester A write request
//   a_ready               : A accepted this cycle (combinational)
//   b_valid/b_addr/b_data : requester B write request
//   b_ready               : B accepted this cycle (combinational)
//   clr_req               : request to zero all registers
//   clr_busy              : clear sweep in progress
//   rf_write              : register-file write enable (registered)
//   rf_inaddress          : register-file write address (registered)
//   rf_in                 : register-file write data (registered)
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,

    input  logic              clr_req,
    output logic              clr_busy,

    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_inaddress,
    output logic [DATA_W-1:0] rf_in
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // 1 when B received the most recent grant; reset to 1 so A wins first
    logic              last_b_q, last_b_d;

    logic              wr_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              grant_a;
    logic              grant_b;

    // Next-state, grant and write-port selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        wr_d     = 1'b0;
        waddr_d  = rf_inaddress;
        wdata_d  = rf_in;
        grant_a  = 1'b0;
        grant_b  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (clr_req) begin
                        // Clear wins over pending writes; they wait for IDLE
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        grant_a = a_valid && (!b_valid || last_b_q);
                        grant_b = b_valid && (!a_valid || !last_b_q);
                    end
                end

                if (grant_a) begin
                    wr_d     = 1'b1;
                    waddr_d  = a_addr;
                    wdata_d  = a_data;
                    last_b_d = 1'b0;
                end else if (grant_b) begin
                    wr_d     = 1'b1;
                    waddr_d  = b_addr;
                    wdata_d  = b_data;
                    last_b_d = 1'b1;
                end
            end

            CLEAR: begin
                wr_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_b_q     <= 1'b1;
            rf_write     <= 1'b0;
            rf_inaddress <= '0;
            rf_in        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_b_q     <= last_b_d;
            rf_write     <= wr_d;
            rf_inaddress <= waddr_d;
            rf_in        <= wdata_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter. Inputs change 1ns after the rising
//   edge; readies are sampled 1ns later and registered outputs 1ns after each
//   edge. A negedge monitor watches for both readies high and for writes with
//   no preceding transfer or clear step.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0;
    logic [2:0] a_addr = 3'd0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [2:0] b_addr = 3'd0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready;
    logic       clr_req = 1'b0;
    logic       clr_busy;
    logic       rf_write;
    logic [2:0] rf_inaddress;
    logic [7:0] rf_in;

    int n_err = 0;
    int n_chk = 0;

    reg_write_arbiter #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .rf_write     (rf_write),
        .rf_inaddress (rf_inaddress),
        .rf_in        (rf_in)
    );

    always #5 clk = ~clk;

    // Register file fed by the write port, used for end-of-sweep contents
    logic [7:0] shadow [8];
    logic       shadow_init = 1'b0;
    always @(posedge clk) begin
        if (shadow_init) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 8'hEE;
        end else if (rf_write === 1'b1) begin
            shadow[rf_inaddress] <= rf_in;
        end
    end

    // Whether the edge just taken carried a transfer or a clear step
    logic prev_step = 1'b0;
    always @(posedge clk) begin
        prev_step <= !reset && ((a_valid && a_ready) || (b_valid && b_ready) ||
                                (clr_busy === 1'b1));
    end

    always @(negedge clk) begin
        n_chk++;
        if (a_ready === 1'b1 && b_ready === 1'b1) begin
            n_err++;
            $display("FAIL ready_exclusive t=%0t a_ready=%b b_ready=%b required not both 1",
                     $time, a_ready, b_ready);
        end
        n_chk++;
        if (rf_write === 1'b1 && !prev_step) begin
            n_err++;
            $display("FAIL spurious_write t=%0t rf_write=%b required 0 (no preceding step)",
                     $time, rf_write);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        a_valid = 1'b1; a_addr = 3'd4; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 3'd6; b_data = 8'h22;
        clr_req = 1'b1;
        tick();
        tick();
        #1;
        n_chk++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready a_ready=%b b_ready=%b required 0 0", a_ready, b_ready);
        end
        n_chk++;
        if (rf_write !== 1'b0 || rf_inaddress !== 3'd0 || rf_in !== 8'h00 || clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs wr=%b addr=%0d data=%h busy=%b required 0 0 00 0",
                     rf_write, rf_inaddress, rf_in, clr_busy);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_addr = 3'b010; a_data = 8'h03;
        #1;
        n_chk++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL a_only_ready a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        n_chk++;
        if (rf_write !== 1'b1 || rf_inaddress !== 3'd2 || rf_in !== 8'h03) begin
            n_err++;
            $display("FAIL a_only_write wr=%b addr=%0d data=%h required 1 2 03",
                     rf_write, rf_inaddress, rf_in);
        end
        tick();
        n_chk++;
        if (rf_write !== 1'b0 || rf_inaddress !== 3'd2 || rf_in !== 8'h03) begin
            n_err++;
            $display("FAIL a_only_hold wr=%b addr=%0d data=%h required 0 2 03",
                     rf_write, rf_inaddress, rf_in);
        end
    endtask

    task automatic test_contention();
        logic exp_a;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 8'hAA;
        b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_a = (i % 2 == 0);
            n_chk++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                n_err++;
                $display("FAIL contention_grant cycle=%0d a_ready=%b b_ready=%b required %b %b",
                         i, a_ready, b_ready, exp_a, !exp_a);
            end
            if (i > 0) begin
                n_chk++;
                if (rf_write !== 1'b1 || rf_inaddress !== (exp_a ? 3'd5 : 3'd1) ||
                    rf_in !== (exp_a ? 8'h55 : 8'hAA)) begin
                    n_err++;
                    $display("FAIL contention_write cycle=%0d wr=%b addr=%0d data=%h",
                             i, rf_write, rf_inaddress, rf_in);
                end
            end
            tick();
        end
        idle_inputs();
        n_chk++;
        if (rf_write !== 1'b1 || rf_inaddress !== 3'd5 || rf_in !== 8'h55) begin
            n_err++;
            $display("FAIL contention_last wr=%b addr=%0d data=%h required 1 5 55",
                     rf_write, rf_inaddress, rf_in);
        end
        tick();
        n_chk++;
        if (rf_write !== 1'b0) begin
            n_err++;
            $display("FAIL contention_idle wr=%b required 0", rf_write);
        end
    endtask

    // Runs the 8 CLEAR cycles starting in the first CLEAR cycle
    task automatic run_sweep(input string tag);
        for (int k = 0; k < 8; k++) begin
            clr_req = (k == 4);     // ignored during the sweep
            #1;
            n_chk++;
            if (clr_busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_busy k=%0d busy=%b a_ready=%b b_ready=%b required 1 0 0",
                         tag, k, clr_busy, a_ready, b_ready);
            end
            if (k > 0) begin
                n_chk++;
                if (rf_write !== 1'b1 || rf_inaddress !== 3'(k - 1) || rf_in !== 8'h00) begin
                    n_err++;
                    $display("FAIL %s_write k=%0d wr=%b addr=%0d data=%h required 1 %0d 00",
                             tag, k, rf_write, rf_inaddress, rf_in, k - 1);
                end
            end
            tick();
        end
        clr_req = 1'b0;
    endtask

    task automatic test_clear();
        clr_req = 1'b1;
        b_valid = 1'b1; b_addr = 3'd6; b_data = 8'h5C;
        #1;
        n_chk++;
        if (b_ready !== 1'b0 || a_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_priority b_ready=%b a_ready=%b required 0 0", b_ready, a_ready);
        end
        tick();
        clr_req = 1'b0;
        n_chk++;
        if (rf_write !== 1'b0) begin
            n_err++;
            $display("FAIL clear_first wr=%b required 0", rf_write);
        end
        run_sweep("clear");
        #1;
        n_chk++;
        if (clr_busy !== 1'b0 || b_ready !== 1'b1 || rf_write !== 1'b1 ||
            rf_inaddress !== 3'd7 || rf_in !== 8'h00) begin
            n_err++;
            $display("FAIL clear_exit busy=%b b_ready=%b wr=%b addr=%0d data=%h required 0 1 1 7 00",
                     clr_busy, b_ready, rf_write, rf_inaddress, rf_in);
        end
        tick();
        b_valid = 1'b0;
        n_chk++;
        if (rf_write !== 1'b1 || rf_inaddress !== 3'd6 || rf_in !== 8'h5C) begin
            n_err++;
            $display("FAIL clear_pending_b wr=%b addr=%0d data=%h required 1 6 5c",
                     rf_write, rf_inaddress, rf_in);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();   // count 0 -> 1
        tick();   // count 1 -> 2
        tick();   // count 2 -> 3
        n_chk++;
        if (clr_busy !== 1'b1 || rf_write !== 1'b1 || rf_inaddress !== 3'd2) begin
            n_err++;
            $display("FAIL midclr_count3 busy=%b wr=%b addr=%0d required 1 1 2",
                     clr_busy, rf_write, rf_inaddress);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if (rf_write !== 1'b0 || clr_busy !== 1'b0 || rf_inaddress !== 3'd0 || rf_in !== 8'h00) begin
            n_err++;
            $display("FAIL midclr_reset wr=%b busy=%b addr=%0d data=%h required 0 0 0 00",
                     rf_write, clr_busy, rf_inaddress, rf_in);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++;
            if (rf_write !== 1'b0 || clr_busy !== 1'b0) begin
                n_err++;
                $display("FAIL midclr_nowrite i=%0d wr=%b busy=%b required 0 0",
                         i, rf_write, clr_busy);
            end
        end
        a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h3C;
        b_valid = 1'b1; b_addr = 3'd4; b_data = 8'h4B;
        #1;
        n_chk++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midclr_first_a a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        shadow_init = 1'b1;
        tick();
        shadow_init = 1'b0;
        a_valid = 1'b1; a_addr = 3'd0; a_data = 8'hFF;
        #1;
        n_chk++;
        if (a_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept a_ready=%b required 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        clr_req = 1'b1;
        #1;
        n_chk++;
        if (rf_write !== 1'b1 || rf_inaddress !== 3'd0 || rf_in !== 8'hFF || a_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ff_first wr=%b addr=%0d data=%h a_ready=%b required 1 0 ff 0",
                     rf_write, rf_inaddress, rf_in, a_ready);
        end
        tick();
        clr_req = 1'b0;
        run_sweep("b2b");
        tick();
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (shadow[i] !== 8'h00) begin
                n_err++;
                $display("FAIL b2b_contents reg=%0d value=%h required 00", i, shadow[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        do_reset();
        test_contention();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t bench did not complete", $time);
        $fatal(1, "timeout");
    end

endmodule
